// File: rtl/kbd_scan_sequencer_if.sv
//------------------------------------------------------------------------------
// kbd_scan_sequencer_if : scan input, translator and CPU-side key handshakes
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface kbd_scan_sequencer_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       tr_shift;
  logic       tr_e0;
  logic [7:0] tr_incode;
  logic [6:0] tr_outcode;
  logic       tr_autoar2;
  logic [6:0] key_code;
  logic       key_ar2;
  logic       key_ready;
  logic       key_ack;
  logic       key_down;
  logic       irq_en;
  logic       irq_req;
  logic       irq_ack;
  logic       overrun;

  modport master (
    output scan_valid, scan_code, tr_outcode, tr_autoar2, key_ack, irq_en, irq_ack,
    input  tr_shift, tr_e0, tr_incode, key_code, key_ar2, key_ready, key_down,
           irq_req, overrun
  );

  modport slave (
    input  scan_valid, scan_code, tr_outcode, tr_autoar2, key_ack, irq_en, irq_ack,
    output tr_shift, tr_e0, tr_incode, key_code, key_ar2, key_ready, key_down,
           irq_req, overrun
  );
endinterface

`default_nettype wire

// File: rtl/kbd_scan_sequencer.sv
//------------------------------------------------------------------------------
// kbd_scan_sequencer : PS/2 set-2 byte parser feeding BK-0010 keyboard registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module kbd_scan_sequencer #(
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int TMO_W          = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  kbd_scan_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXT    = 3'd1;
  localparam logic [2:0] S_BRK    = 3'd2;
  localparam logic [2:0] S_E1SKIP = 3'd3;
  localparam logic [2:0] S_XLATE  = 3'd4;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [2:0] E1_TAIL   = 3'd7;

  logic [2:0]       r_state, w_state_nxt;
  logic             r_ext, r_shift_l;
  logic [2:0]       r_skip;
  logic [TMO_W-1:0] r_tmo;
  logic [8:0]       r_last_key;
  logic             r_tr_shift, r_tr_e0;
  logic [7:0]       r_tr_incode;
  logic [6:0]       r_key_code;
  logic             r_key_ar2, r_key_ready, r_key_down, r_irq_req, r_overrun;

  logic w_in_wait, w_tmo_hit, w_is_e0, w_is_e1, w_is_f0, w_is_shift;
  logic w_make, w_set_ext, w_set_shift, w_clr_shift, w_load_tr, w_brk_match;
  logic w_hit, w_deliver, w_drop, w_e1_start, w_skip_dec;

  assign w_in_wait  = (r_state == S_EXT) || (r_state == S_BRK) || (r_state == S_E1SKIP);
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_is_e0    = (bus.scan_code == SC_E0);
  assign w_is_e1    = (bus.scan_code == SC_E1);
  assign w_is_f0    = (bus.scan_code == SC_F0);
  assign w_is_shift = (bus.scan_code == SC_LSHIFT);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A byte arriving in the same cycle as the timeout still counts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.scan_valid) begin
        if (w_is_e0)         w_state_nxt = S_EXT;
        else if (w_is_f0)    w_state_nxt = S_BRK;
        else if (w_is_e1)    w_state_nxt = S_E1SKIP;
        else if (w_is_shift) w_state_nxt = S_IDLE;
        else                 w_state_nxt = S_XLATE;
      end
      S_EXT: begin
        if (bus.scan_valid) begin
          if (w_is_f0)         w_state_nxt = S_BRK;
          else if (w_is_shift) w_state_nxt = S_IDLE;
          else                 w_state_nxt = S_XLATE;
        end else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_BRK: begin
        if (bus.scan_valid || w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_E1SKIP: begin
        if (bus.scan_valid) begin
          if (r_skip == 3'd1) w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) w_state_nxt = S_IDLE;
      end
      S_XLATE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_make      = bus.scan_valid &&
                  (((r_state == S_IDLE) && !w_is_e0 && !w_is_f0 && !w_is_e1) ||
                   ((r_state == S_EXT) && !w_is_f0));
    w_set_ext   = bus.scan_valid && (r_state == S_IDLE) && w_is_e0;
    w_set_shift = w_make && w_is_shift && (r_state == S_IDLE);
    w_load_tr   = w_make && !w_is_shift;
    w_clr_shift = bus.scan_valid && (r_state == S_BRK) && w_is_shift && !r_ext;
    w_brk_match = bus.scan_valid && (r_state == S_BRK) && ({r_ext, bus.scan_code} == r_last_key);
    w_hit       = (r_state == S_XLATE) && (bus.tr_outcode != 7'd0);
    w_deliver   = w_hit && (!r_key_ready || bus.key_ack);
    w_drop      = w_hit && r_key_ready && !bus.key_ack;
    w_e1_start  = bus.scan_valid && (r_state == S_IDLE) && w_is_e1;
    w_skip_dec  = bus.scan_valid && (r_state == S_E1SKIP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ext       <= 1'b0;
      r_shift_l   <= 1'b0;
      r_skip      <= 3'd0;
      r_tmo       <= '0;
      r_last_key  <= 9'd0;
      r_tr_shift  <= 1'b0;
      r_tr_e0     <= 1'b0;
      r_tr_incode <= 8'd0;
      r_key_code  <= 7'd0;
      r_key_ar2   <= 1'b0;
      r_key_ready <= 1'b0;
      r_key_down  <= 1'b0;
      r_irq_req   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_state_nxt == S_IDLE) r_ext <= 1'b0;
      else if (w_set_ext)        r_ext <= 1'b1;

      if (bus.scan_valid || !w_in_wait || (w_state_nxt == S_IDLE)) r_tmo <= '0;
      else                                                         r_tmo <= r_tmo + 1'b1;

      if (w_e1_start)      r_skip <= E1_TAIL;
      else if (w_skip_dec) r_skip <= r_skip - 3'd1;

      if (w_set_shift)      r_shift_l <= 1'b1;
      else if (w_clr_shift) r_shift_l <= 1'b0;

      if (w_load_tr) begin
        r_tr_incode <= bus.scan_code;
        r_tr_e0     <= (r_state == S_EXT);
        r_tr_shift  <= r_shift_l;
      end

      if (w_hit) begin
        r_key_down <= 1'b1;
        r_last_key <= {r_tr_e0, r_tr_incode};
      end else if (w_brk_match) begin
        r_key_down <= 1'b0;
      end

      if (w_deliver) begin
        r_key_code <= bus.tr_outcode;
        r_key_ar2  <= bus.tr_autoar2;
      end

      if (w_deliver)        r_key_ready <= 1'b1;
      else if (bus.key_ack) r_key_ready <= 1'b0;

      // irq_en is level-checked, so re-enabling never resurrects a cleared request.
      if (w_deliver && bus.irq_en)                       r_irq_req <= 1'b1;
      else if (bus.key_ack || bus.irq_ack || !bus.irq_en) r_irq_req <= 1'b0;

      if (bus.key_ack)  r_overrun <= 1'b0;
      else if (w_drop)  r_overrun <= 1'b1;
    end
  end

  assign bus.tr_shift  = r_tr_shift;
  assign bus.tr_e0     = r_tr_e0;
  assign bus.tr_incode = r_tr_incode;
  assign bus.key_code  = r_key_code;
  assign bus.key_ar2   = r_key_ar2;
  assign bus.key_ready = r_key_ready;
  assign bus.key_down  = r_key_down;
  assign bus.irq_req   = r_irq_req;
  assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire
